// File: rtl/core_dataslot_pkg.sv
// Shared definitions for the core-side dataslot responder: FSM states, request kinds and
// the datatable slot layout.
package core_dataslot_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdId,
        StCmpId,
        StRdSize,
        StChk,
        StAck,
        StTblWr,
        StUserWr,
        StWaitDrop
    } state_e;

    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpUser
    } op_e;

    // Each table entry is two words: slot ID then slot size.
    localparam int unsigned IdWordOfs   = 0;
    localparam int unsigned SizeWordOfs = 1;
    localparam int unsigned SlotStride  = 2;

    localparam logic RespOk  = 1'b1;
    localparam logic RespErr = 1'b0;

    function automatic logic [9:0] slot_word(input int unsigned idx, input int unsigned ofs);
        return 10'(idx * SlotStride + ofs);
    endfunction

endpackage

// File: rtl/core_dataslot_ctrl.sv
// Core-side responder for host dataslot read/write requests: searches the slot table on
// datatable port A, validates sizes, acks the bridge and shares the port with size updates.
module core_dataslot_ctrl
    import core_dataslot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned RD_LAT        = 2,
    parameter logic [31:0] MAX_LOAD_SIZE = 32'h0080_0000,
    parameter logic [31:0] MAX_SAVE_SIZE = 32'h0002_0000,
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             dataslot_requestread,
    input  logic [15:0]      dataslot_requestread_id,
    output logic             dataslot_requestread_ack,
    output logic             dataslot_requestread_ok,

    input  logic             dataslot_requestwrite,
    input  logic [15:0]      dataslot_requestwrite_id,
    input  logic [31:0]      dataslot_requestwrite_size,
    output logic             dataslot_requestwrite_ack,
    output logic             dataslot_requestwrite_ok,

    output logic [9:0]       datatable_addr,
    output logic             datatable_wren,
    output logic [31:0]      datatable_data,
    input  logic [31:0]      datatable_q,

    input  logic             user_wr_req,
    input  logic [IDX_W-1:0] user_wr_slot,
    input  logic [31:0]      user_wr_size,
    output logic             user_wr_ack,

    output logic             slot_read_go,
    output logic [IDX_W-1:0] slot_read_index,
    output logic [31:0]      slot_read_size
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [15:0]      id_q, id_d;
    logic [31:0]      size_q, size_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [7:0]       wait_q, wait_d;
    logic             ok_q, ok_d;
    logic [9:0]       addr_q, addr_d;
    logic [IDX_W-1:0] user_slot_q, user_slot_d;
    logic [IDX_W-1:0] rd_index_q, rd_index_d;
    logic [31:0]      rd_size_q, rd_size_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            op_q        <= OpRead;
            id_q        <= '0;
            size_q      <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            ok_q        <= RespErr;
            addr_q      <= '0;
            user_slot_q <= '0;
            rd_index_q  <= '0;
            rd_size_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            size_q      <= size_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            ok_q        <= ok_d;
            addr_q      <= addr_d;
            user_slot_q <= user_slot_d;
            rd_index_q  <= rd_index_d;
            rd_size_q   <= rd_size_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        size_d      = size_q;
        k_d         = k_q;
        wait_d      = wait_q;
        ok_d        = ok_q;
        addr_d      = addr_q;
        user_slot_d = user_slot_q;
        rd_index_d  = rd_index_q;
        rd_size_d   = rd_size_q;

        dataslot_requestread_ack  = 1'b0;
        dataslot_requestread_ok   = 1'b0;
        dataslot_requestwrite_ack = 1'b0;
        dataslot_requestwrite_ok  = 1'b0;
        datatable_wren            = 1'b0;
        datatable_data            = '0;
        user_wr_ack               = 1'b0;
        slot_read_go              = 1'b0;

        case (state_q)
            StIdle: begin
                k_d    = '0;
                wait_d = '0;
                if (dataslot_requestread) begin
                    op_d    = OpRead;
                    id_d    = dataslot_requestread_id;
                    addr_d  = slot_word(0, IdWordOfs);
                    state_d = StRdId;
                end else if (dataslot_requestwrite) begin
                    op_d    = OpWrite;
                    id_d    = dataslot_requestwrite_id;
                    size_d  = dataslot_requestwrite_size;
                    addr_d  = slot_word(0, IdWordOfs);
                    state_d = StRdId;
                end else if (user_wr_req) begin
                    op_d        = OpUser;
                    user_slot_d = user_wr_slot;
                    size_d      = user_wr_size;
                    addr_d      = slot_word(32'(user_wr_slot), SizeWordOfs);
                    state_d     = StUserWr;
                end
            end
            // Address is held for the whole read; q is sampled in the following state.
            StRdId: begin
                if (wait_q == 8'(RD_LAT - 1)) state_d = StCmpId;
                else                          wait_d  = wait_q + 8'd1;
            end
            StCmpId: begin
                wait_d = '0;
                if (datatable_q[15:0] == id_q) begin
                    addr_d  = slot_word(32'(k_q), SizeWordOfs);
                    state_d = StRdSize;
                end else if (32'(k_q) == NUM_SLOTS - 1) begin
                    ok_d    = RespErr;
                    state_d = StAck;
                end else begin
                    k_d     = k_q + 1'b1;
                    addr_d  = slot_word(32'(k_q) + 32'd1, IdWordOfs);
                    state_d = StRdId;
                end
            end
            StRdSize: begin
                if (wait_q == 8'(RD_LAT - 1)) state_d = StChk;
                else                          wait_d  = wait_q + 8'd1;
            end
            StChk: begin
                if (op_q == OpRead) begin
                    ok_d = (datatable_q != '0) && (datatable_q <= MAX_LOAD_SIZE);
                    if (ok_d) begin
                        rd_index_d = k_q;
                        rd_size_d  = datatable_q;
                    end
                end else begin
                    ok_d = (size_q != '0) && (size_q <= MAX_SAVE_SIZE);
                end
                state_d = StAck;
            end
            StAck: begin
                if (op_q == OpRead) begin
                    dataslot_requestread_ack = 1'b1;
                    dataslot_requestread_ok  = ok_q;
                    slot_read_go             = ok_q;
                    state_d                  = StWaitDrop;
                end else begin
                    dataslot_requestwrite_ack = 1'b1;
                    dataslot_requestwrite_ok  = ok_q;
                    state_d                   = ok_q ? StTblWr : StWaitDrop;
                end
            end
            // addr_q still points at the matched entry's size word.
            StTblWr: begin
                datatable_wren = 1'b1;
                datatable_data = size_q;
                state_d        = StWaitDrop;
            end
            StUserWr: begin
                user_wr_ack = 1'b1;
                if (32'(user_slot_q) < NUM_SLOTS) begin
                    datatable_wren = 1'b1;
                    datatable_data = size_q;
                end
                state_d = StIdle;
            end
            StWaitDrop: begin
                if (op_q == OpRead) begin
                    if (!dataslot_requestread) state_d = StIdle;
                end else if (!dataslot_requestwrite) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign datatable_addr  = addr_q;
    assign slot_read_index = rd_index_q;
    assign slot_read_size  = rd_size_q;

endmodule

// File: tb/tb_core_dataslot_ctrl.sv
// Randomised self-checking bench for core_dataslot_ctrl with a latency-modelled datatable and
// a slot-table reference model.
module tb_core_dataslot_ctrl;

    localparam int unsigned NUM_SLOTS     = 4;
    localparam int unsigned RD_LAT        = 2;
    localparam logic [31:0] MAX_LOAD_SIZE = 32'h0080_0000;
    localparam logic [31:0] MAX_SAVE_SIZE = 32'h0002_0000;
    localparam int unsigned IDX_W         = $clog2(NUM_SLOTS);

    logic             clk;
    logic             reset_n;
    logic             dataslot_requestread;
    logic [15:0]      dataslot_requestread_id;
    logic             dataslot_requestread_ack;
    logic             dataslot_requestread_ok;
    logic             dataslot_requestwrite;
    logic [15:0]      dataslot_requestwrite_id;
    logic [31:0]      dataslot_requestwrite_size;
    logic             dataslot_requestwrite_ack;
    logic             dataslot_requestwrite_ok;
    logic [9:0]       datatable_addr;
    logic             datatable_wren;
    logic [31:0]      datatable_data;
    logic [31:0]      datatable_q;
    logic             user_wr_req;
    logic [IDX_W-1:0] user_wr_slot;
    logic [31:0]      user_wr_size;
    logic             user_wr_ack;
    logic             slot_read_go;
    logic [IDX_W-1:0] slot_read_index;
    logic [31:0]      slot_read_size;

    core_dataslot_ctrl #(
        .NUM_SLOTS    (NUM_SLOTS),
        .RD_LAT       (RD_LAT),
        .MAX_LOAD_SIZE(MAX_LOAD_SIZE),
        .MAX_SAVE_SIZE(MAX_SAVE_SIZE)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .dataslot_requestread      (dataslot_requestread),
        .dataslot_requestread_id   (dataslot_requestread_id),
        .dataslot_requestread_ack  (dataslot_requestread_ack),
        .dataslot_requestread_ok   (dataslot_requestread_ok),
        .dataslot_requestwrite     (dataslot_requestwrite),
        .dataslot_requestwrite_id  (dataslot_requestwrite_id),
        .dataslot_requestwrite_size(dataslot_requestwrite_size),
        .dataslot_requestwrite_ack (dataslot_requestwrite_ack),
        .dataslot_requestwrite_ok  (dataslot_requestwrite_ok),
        .datatable_addr            (datatable_addr),
        .datatable_wren            (datatable_wren),
        .datatable_data            (datatable_data),
        .datatable_q               (datatable_q),
        .user_wr_req               (user_wr_req),
        .user_wr_slot              (user_wr_slot),
        .user_wr_size              (user_wr_size),
        .user_wr_ack               (user_wr_ack),
        .slot_read_go              (slot_read_go),
        .slot_read_index           (slot_read_index),
        .slot_read_size            (slot_read_size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datatable port A: RD_LAT register stages, plus a backdoor poke port for the bench.
    logic [31:0] mem  [1024];
    logic [31:0] pipe [RD_LAT];
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;

    always @(posedge clk) begin
        if (poke_en)             mem[poke_addr]      <= poke_data;
        else if (datatable_wren) mem[datatable_addr] <= datatable_data;
        pipe[0] <= mem[datatable_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign datatable_q = pipe[RD_LAT-1];

    int          rd_ack_cnt = 0, wr_ack_cnt = 0, go_cnt = 0, user_ack_cnt = 0;
    logic [9:0]  wr_log_addr [$];
    logic [31:0] wr_log_data [$];

    always @(negedge clk) begin
        if (dataslot_requestread_ack)  rd_ack_cnt++;
        if (dataslot_requestwrite_ack) wr_ack_cnt++;
        if (slot_read_go)              go_cnt++;
        if (user_wr_ack)               user_ack_cnt++;
        if (datatable_wren) begin
            wr_log_addr.push_back(datatable_addr);
            wr_log_data.push_back(datatable_data);
        end
    end

    // Reference model of the slot table contents.
    logic [15:0] ref_id   [NUM_SLOTS];
    logic [31:0] ref_size [NUM_SLOTS];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int find_slot(input logic [15:0] id);
        for (int i = 0; i < NUM_SLOTS; i++) if (ref_id[i] == id) return i;
        return -1;
    endfunction

    function automatic int exp_latency(input int k);
        return (k >= 0) ? 1 + (k + 2) * (RD_LAT + 1) : 1 + NUM_SLOTS * (RD_LAT + 1);
    endfunction

    function automatic logic [31:0] rand_size();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 'h1000));
            2:       return MAX_SAVE_SIZE;
            3:       return MAX_SAVE_SIZE + 32'd1;
            4:       return MAX_LOAD_SIZE;
            5:       return MAX_LOAD_SIZE + 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int slot, input logic [31:0] id_word, input logic [31:0] size);
        poke_en = 1'b1; poke_addr = 10'(2 * slot); poke_data = id_word;
        tick();
        poke_addr = 10'(2 * slot + 1); poke_data = size;
        tick();
        poke_en = 1'b0;
        ref_id[slot]   = id_word[15:0];
        ref_size[slot] = size;
    endtask

    task automatic do_read(input logic [15:0] id, input int hold);
        int k, lat, n, rd0, go0, wr0;
        logic exp_ok;
        bit seen;
        k      = find_slot(id);
        lat    = exp_latency(k);
        exp_ok = (k >= 0) && (ref_size[k] != 0) && (ref_size[k] <= MAX_LOAD_SIZE);
        rd0 = rd_ack_cnt; go0 = go_cnt; wr0 = wr_log_addr.size();
        dataslot_requestread_id = id;
        dataslot_requestread    = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 64) begin
            tick(); n++;
            seen = dataslot_requestread_ack;
        end
        n_checks++;
        if (!seen || n != lat) begin
            n_fail++;
            $display("FAIL read_latency id=%h: got %0d cycles (seen=%0b), expected %0d", id, n,
                     seen, lat);
        end
        if (seen) begin
            n_checks++;
            if (dataslot_requestread_ok !== exp_ok || slot_read_go !== exp_ok) begin
                n_fail++;
                $display("FAIL read_ok id=%h: got ok=%b go=%b, expected %b", id,
                         dataslot_requestread_ok, slot_read_go, exp_ok);
            end
            if (exp_ok) begin
                n_checks++;
                if (slot_read_index !== IDX_W'(k) || slot_read_size !== ref_size[k]) begin
                    n_fail++;
                    $display("FAIL read_slot id=%h: got index=%0d size=%h, expected %0d %h", id,
                             slot_read_index, slot_read_size, k, ref_size[k]);
                end
            end
        end
        repeat (hold) tick();
        dataslot_requestread = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (rd_ack_cnt - rd0 != 1 || go_cnt - go0 != int'(exp_ok) || wr_log_addr.size() != wr0)
        begin
            n_fail++;
            $display("FAIL read_counts id=%h: got acks=%0d gos=%0d writes=%0d, expected 1 %0d 0",
                     id, rd_ack_cnt - rd0, go_cnt - go0, wr_log_addr.size() - wr0, exp_ok);
        end
    endtask

    task automatic do_write(input logic [15:0] id, input logic [31:0] size);
        int k, lat, n, wr0, wa0;
        logic exp_ok;
        bit seen;
        k      = find_slot(id);
        lat    = exp_latency(k);
        exp_ok = (k >= 0) && (size != 0) && (size <= MAX_SAVE_SIZE);
        wa0 = wr_ack_cnt; wr0 = wr_log_addr.size();
        dataslot_requestwrite_id   = id;
        dataslot_requestwrite_size = size;
        dataslot_requestwrite      = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 64) begin
            tick(); n++;
            seen = dataslot_requestwrite_ack;
        end
        n_checks++;
        if (!seen || n != lat || dataslot_requestwrite_ok !== exp_ok) begin
            n_fail++;
            $display("FAIL write_ack id=%h size=%h: got %0d cycles seen=%0b ok=%b, expected %0d %b",
                     id, size, n, seen, dataslot_requestwrite_ok, lat, exp_ok);
        end
        tick();
        dataslot_requestwrite = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (wr_ack_cnt - wa0 != 1 || wr_log_addr.size() - wr0 != int'(exp_ok)) begin
            n_fail++;
            $display("FAIL write_counts id=%h: got acks=%0d writes=%0d, expected 1 %0d", id,
                     wr_ack_cnt - wa0, wr_log_addr.size() - wr0, exp_ok);
        end else if (exp_ok) begin
            n_checks++;
            if (wr_log_addr[wr0] !== 10'(2 * k + 1) || wr_log_data[wr0] !== size) begin
                n_fail++;
                $display("FAIL write_table id=%h: got addr=%0d data=%h, expected %0d %h", id,
                         wr_log_addr[wr0], wr_log_data[wr0], 2 * k + 1, size);
            end
            ref_size[k] = size;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (dataslot_requestread_ack !== 1'b0 || dataslot_requestread_ok !== 1'b0 ||
            dataslot_requestwrite_ack !== 1'b0 || dataslot_requestwrite_ok !== 1'b0 ||
            user_wr_ack !== 1'b0 || slot_read_go !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_handshake: got rack=%b rok=%b wack=%b wok=%b uack=%b go=%b, expected 0",
                     name, dataslot_requestread_ack, dataslot_requestread_ok,
                     dataslot_requestwrite_ack, dataslot_requestwrite_ok, user_wr_ack,
                     slot_read_go);
        end
        n_checks++;
        if (datatable_addr !== '0 || datatable_wren !== 1'b0 || datatable_data !== '0 ||
            slot_read_index !== '0 || slot_read_size !== '0) begin
            n_fail++;
            $display("FAIL %s_datapath: got addr=%h wren=%b data=%h idx=%h size=%h, expected 0",
                     name, datatable_addr, datatable_wren, datatable_data, slot_read_index,
                     slot_read_size);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dataslot_requestread = 0; dataslot_requestread_id = '0;
        dataslot_requestwrite = 0; dataslot_requestwrite_id = '0;
        dataslot_requestwrite_size = '0;
        user_wr_req = 0; user_wr_slot = '0; user_wr_size = '0;
        poke_en = 0; poke_addr = '0; poke_data = '0;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();
    endtask

    task automatic load_directed();
        set_entry(0, 32'hABCD_0005, 32'h0000_1000);
        set_entry(1, 32'h0000_0009, 32'h0000_0000);
        set_entry(2, 32'hFFFF_0011, 32'h0002_0000);
        set_entry(3, 32'h0000_0022, MAX_LOAD_SIZE + 32'd1);
    endtask

    task automatic test_read_paths();
        do_read(16'h0005, 0);
        do_read(16'h0009, 0);
        do_read(16'h0007, 0);
        do_read(16'h0022, 0);
    endtask

    task automatic test_write_then_read();
        do_write(16'h0009, 32'h0000_0800);
        do_read(16'h0009, 0);
    endtask

    task automatic test_back_to_back_hold();
        do_read(16'h0005, 5);
        do_read(16'h0011, 5);
    endtask

    task automatic test_user_priority();
        int u0, n, lat;
        bit seen;
        logic [31:0] sz;
        sz  = 32'($urandom_range(1, 'hFFFF));
        u0  = user_ack_cnt;
        lat = exp_latency(find_slot(16'h0005));
        dataslot_requestread_id = 16'h0005;
        user_wr_slot = IDX_W'(2); user_wr_size = sz;
        dataslot_requestread = 1'b1; user_wr_req = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 64) begin
            tick(); n++;
            seen = dataslot_requestread_ack;
        end
        n_checks++;
        if (!seen || n != lat || user_ack_cnt != u0) begin
            n_fail++;
            $display("FAIL user_prio_read: got %0d cycles seen=%0b uacks=%0d, expected %0d 1 0",
                     n, seen, user_ack_cnt - u0, lat);
        end
        repeat (2) tick();
        dataslot_requestread = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 10) begin
            tick(); n++;
            seen = user_wr_ack;
        end
        n_checks++;
        if (!seen || n != 2 || datatable_wren !== 1'b1 || datatable_addr !== 10'd5 ||
            datatable_data !== sz) begin
            n_fail++;
            $display("FAIL user_write: got cycles=%0d seen=%0b wren=%b addr=%0d data=%h, expected 2 1 1 5 %h",
                     n, seen, datatable_wren, datatable_addr, datatable_data, sz);
        end
        user_wr_req = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (user_ack_cnt - u0 != 1) begin
            n_fail++;
            $display("FAIL user_ack_count: got %0d, expected 1", user_ack_cnt - u0);
        end
        ref_size[2] = sz;
        do_read(16'h0011, 0);
    endtask

    task automatic test_reset_mid_search();
        int rd0;
        rd0 = rd_ack_cnt;
        dataslot_requestread_id = 16'h7777;
        dataslot_requestread    = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        check_outputs_zero("mid_reset");
        reset_n = 1'b1;
        dataslot_requestread = 1'b0;
        repeat (16) tick();
        n_checks++;
        if (rd_ack_cnt != rd0) begin
            n_fail++;
            $display("FAIL mid_reset_no_ack: got %0d acks, expected 0", rd_ack_cnt - rd0);
        end
        do_read(16'h0005, 0);
    endtask

    task automatic test_boundaries();
        set_entry(3, 32'h0000_0022, MAX_LOAD_SIZE);
        do_read(16'h0022, 0);
        set_entry(3, 32'h5A5A_0022, MAX_LOAD_SIZE + 32'd1);
        do_read(16'h0022, 0);
        do_write(16'h0011, MAX_SAVE_SIZE);
        do_write(16'h0011, MAX_SAVE_SIZE + 32'd1);
        do_write(16'h0011, 32'd0);
        set_entry(3, 32'h0000_0005, 32'h0000_0040);
        do_read(16'h0005, 0);
        do_write(16'h0005, 32'h0000_0100);
        do_write(16'h0044, 32'h0000_0100);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                set_entry(s, {16'($urandom), 16'($urandom_range(1, 6))}, rand_size());
            for (int t = 0; t < 4; t++) begin
                if ($urandom_range(0, 1) == 0) do_read(16'($urandom_range(1, 7)),
                                                       $urandom_range(0, 2));
                else do_write(16'($urandom_range(1, 7)), rand_size());
            end
        end
    endtask

    initial begin
        test_reset();
        load_directed();
        test_read_paths();
        test_write_then_read();
        test_back_to_back_hold();
        test_user_priority();
        test_reset_mid_search();
        test_boundaries();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_dataslot_ctrl.md
Name: core_dataslot_ctrl

Overview:
Core-side responder for host dataslot read/write requests raised by the bridge command handler.
- Owns datatable port A. Searches the slot table (pairs of words: slot ID, slot size) for the requested ID, validates the size, then returns ack/ok.
- On a successful write request, writes the new size back into the table.
- Shares port A with a core-side size-update requester and hands accepted reads to the downstream loader.

Parameters:
NUM_SLOTS, 4, number of table entries searched (entry i: ID at word 2i, size at word 2i+1)
RD_LAT, 2, clocks from datatable address issue to valid datatable_q
MAX_LOAD_SIZE, 32'h0080_0000, maximum byte size accepted for a read
MAX_SAVE_SIZE, 32'h0002_0000, maximum byte size accepted for a write

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
dataslot_requestread  in  1  level; held until ack seen
dataslot_requestread_id  in  16  slot ID to read
dataslot_requestread_ack  out  1  one-cycle ack
dataslot_requestread_ok  out  1  valid with ack; 1 = accepted
dataslot_requestwrite  in  1  level; held until ack seen
dataslot_requestwrite_id  in  16  slot ID to write
dataslot_requestwrite_size  in  32  requested bytes
dataslot_requestwrite_ack  out  1  one-cycle ack
dataslot_requestwrite_ok  out  1  valid with ack
datatable_addr  out  10  port A word address
datatable_wren  out  1  port A write enable
datatable_data  out  32  port A write data
datatable_q  in  32  port A read data
user_wr_req  in  1  level; core requests a size update
user_wr_slot  in  log2(NUM_SLOTS)  entry index
user_wr_size  in  32  size to store
user_wr_ack  out  1  one-cycle pulse on the cycle the write issues
slot_read_go  out  1  one-cycle pulse after an accepted read
slot_read_index  out  log2(NUM_SLOTS)  matched entry, held until next go
slot_read_size  out  32  table size of matched entry, held until next go

Behaviour:
- Reset (reset_n low at a clock edge): every output is 0 and the FSM returns to IDLE on that edge.
  - This applies mid-operation: an in-flight search is aborted with no ack.
  - A table write is never half-issued, because wren only lasts one cycle.
- FSM states: IDLE, RD_ID, CMP_ID, RD_SIZE, CHK, ACK, TBL_WR, USER_WR, WAIT_DROP.
- IDLE arbitration priority is requestread, then requestwrite, then user_wr_req.
  - The winning request's ID and size are latched.
  - Entry index k is reset to 0.
- Each table read drives datatable_addr for one cycle, waits RD_LAT cycles, and samples datatable_q on the last cycle. One read costs RD_LAT+1 cycles.
  - RD_ID/CMP_ID: read word 2k and compare its [15:0] with the latched ID.
    - Match: go to RD_SIZE.
    - No match and k < NUM_SLOTS-1: k+1, back to RD_ID.
    - No match and k = NUM_SLOTS-1: go to ACK with ok=0.
  - RD_SIZE: read word 2k+1, then go to CHK.
- CHK acceptance rules:
  - Read: ok = (size != 0) and (size <= MAX_LOAD_SIZE).
  - Write: ok = (req size != 0) and (req size <= MAX_SAVE_SIZE).
  - Comparisons are 32-bit unsigned.
- ACK: assert the matching ack for exactly one cycle, with ok valid in the same cycle.
  - Accepted read: slot_read_go pulses in the same cycle; slot_read_index and slot_read_size update.
  - Accepted write: go to TBL_WR, which writes word 2k+1 with the requested size for one cycle (wren=1) and then goes to WAIT_DROP.
  - Otherwise go to WAIT_DROP.
- WAIT_DROP: stay until the serviced request input is low, then go to IDLE. This prevents a double ack while the bridge clears its request.
- USER_WR: one cycle with wren=1, addr = 2*user_wr_slot+1, data = user_wr_size, and user_wr_ack=1. Then return to IDLE; there is no drop wait.
  - user_wr_slot >= NUM_SLOTS: ack with no write.
- Latency, measured from the request first sampled high in IDLE (cycle 0):
  - Match at entry k: ack at cycle 1 + (k+2)(RD_LAT+1).
  - No match: ack at cycle 1 + NUM_SLOTS(RD_LAT+1).
  - With defaults: k=0 gives 7 cycles; not found gives 13.
- A request that rises while another is in service waits for IDLE.
- Requests dropping mid-search are ignored; the search completes and acks.
- A duplicate ID in the table resolves to the lowest index.
- datatable_addr holds its last value when idle; wren is 0 except in TBL_WR/USER_WR.

Decomposition:
- Shared package core_dataslot_pkg holds the state encoding, the table layout constants (ID word offset 0, size word offset 1, stride 2) and the ok/err code constants.
- No sub-module. The port A mux and the search counter are inline. The FSM is small enough for one module.

Test Plan:
- Table {ID 5: 0x1000, ID 9: 0}; requestread id=5 -> ack at cycle 7, ok=1, slot_read_go with index 0, size 0x1000.
- requestread id=9 -> ack at cycle 10, ok=0, no slot_read_go.
- requestread id=7 (absent) -> ack at cycle 13, ok=0.
- requestwrite id=9 size=0x800 -> ack ok=1, one wren to addr 3 with data 0x800; a following read of id 9 returns size 0x800.
- user_wr_req raised together with requestread -> read serviced first; user_wr_ack pulses right after WAIT_DROP releases.
- requestread held high for 5 cycles after ack -> exactly one ack.
- reset_n pulsed low mid-search -> no ack, outputs 0, and the next request is serviced normally.
